// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the M-stage store path and the DM
// write port. Accepts one store per cycle, drains one per cycle when the DM
// port is free, and forwards pending store bytes to younger loads.
// Optional feature macro: STORE_COALESCE_EN (merge a store into the youngest
// entry when the word address matches).
module store_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              st_valid_i,
   output logic              st_ready_o,
   input  logic [ADDR_W-1:0] st_addr_i,
   input  logic [31:0]       st_data_i,
   input  logic [3:0]        st_be_i,
   input  logic [31:0]       st_pc_i,
   input  logic              drain_en_i,
   output logic              dm_we_o,
   output logic [ADDR_W-1:0] dm_addr_o,
   output logic [31:0]       dm_wd_o,
   output logic [3:0]        dm_be_o,
   output logic [31:0]       dm_pc_o,
   input  logic [ADDR_W-1:0] ld_addr_i,
   output logic [3:0]        ld_hit_be_o,
   output logic [31:0]       ld_data_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TAG_W = ADDR_W - 2;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [31:0]      data;
      logic [3:0]       be;
      logic [31:0]      pc;
   } entry_t;

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, tail_q;
   logic [CNT_W-1:0] count_q;

   logic             empty, full, push, pop, merge, alloc;
   logic [PTR_W-1:0] youngest;
   logic [TAG_W-1:0] st_tag, ld_tag;
   entry_t           new_e, mrg_e, head_e;

   assign st_tag   = st_addr_i[ADDR_W-1:2];
   assign ld_tag   = ld_addr_i[ADDR_W-1:2];
   assign empty    = (count_q == '0);
   assign full     = (count_q == CNT_W'(DEPTH));
   assign youngest = tail_q - PTR_W'(1);
   assign head_e   = mem_q[head_q];

   // Ready depends only on registered occupancy, never on this cycle's drain.
   assign st_ready_o = !full;
   assign pop        = !empty && drain_en_i;
   assign push       = st_valid_i && st_ready_o && (st_be_i != 4'b0000);

   // Merge candidate: the youngest entry, unless it is the head leaving now.
`ifdef STORE_COALESCE_EN
   assign merge = push && !empty && (mem_q[youngest].tag == st_tag)
                  && !((count_q == CNT_W'(1)) && pop);
`else
   assign merge = 1'b0;
`endif
   assign alloc = push && !merge;

   // Build the freshly allocated entry and the merged youngest entry.
   always_comb begin
      new_e      = '0;
      new_e.tag  = st_tag;
      new_e.data = st_data_i;
      new_e.be   = st_be_i;
      new_e.pc   = st_pc_i;
      mrg_e      = mem_q[youngest];
      mrg_e.be   = mem_q[youngest].be | st_be_i;
      mrg_e.pc   = st_pc_i;
      for (int l = 0; l < 4; l++) begin
         if (st_be_i[l]) mrg_e.data[8*l +: 8] = st_data_i[8*l +: 8];
      end
   end

   // Entry storage; contents are don't-care after reset so no reset here.
   always_ff @(posedge clk_i) begin
      if (alloc)      mem_q[tail_q]   <= new_e;
      else if (merge) mem_q[youngest] <= mrg_e;
   end

   // Pointer and occupancy update; push and pop may coincide.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q <= head_q + PTR_W'(pop);
         tail_q <= tail_q + PTR_W'(alloc);
         case ({alloc, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // DM port shows the head entry, zeroed when there is nothing pending.
   always_comb begin
      dm_we_o   = pop;
      dm_addr_o = '0;
      dm_wd_o   = '0;
      dm_be_o   = '0;
      dm_pc_o   = '0;
      if (!empty) begin
         dm_addr_o = {head_e.tag, 2'b00};
         dm_wd_o   = head_e.data;
         dm_be_o   = head_e.be;
         dm_pc_o   = head_e.pc;
      end
   end

   // Forwarding: walk oldest to youngest so the youngest match wins per lane.
   always_comb begin
      ld_hit_be_o = '0;
      ld_data_o   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CNT_W'(i) < count_q && mem_q[head_q + PTR_W'(i)].tag == ld_tag) begin
            for (int l = 0; l < 4; l++) begin
               if (mem_q[head_q + PTR_W'(i)].be[l]) begin
                  ld_hit_be_o[l]      = 1'b1;
                  ld_data_o[8*l +: 8] = mem_q[head_q + PTR_W'(i)].data[8*l +: 8];
               end
            end
         end
      end
   end

   assign count_o = count_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer (DEPTH=4): table of per-cycle vectors plus
// a hand-written asynchronous reset sequence. Expectations follow the
// STORE_COALESCE_EN setting of the build.
module tb_store_buffer;

`ifdef STORE_COALESCE_EN
   localparam bit C = 1'b1;
`else
   localparam bit C = 1'b0;
`endif

   logic        clk, rst_n;
   logic        st_valid, st_ready, drain_en, dm_we;
   logic [31:0] st_addr, st_data, st_pc, dm_addr, dm_wd, dm_pc, ld_addr, ld_data;
   logic [3:0]  st_be, dm_be, ld_hit_be;
   logic [2:0]  count;

   int ncmp = 0;
   int nerr = 0;

   store_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
      .clk_i(clk), .reset_ni(rst_n),
      .st_valid_i(st_valid), .st_ready_o(st_ready),
      .st_addr_i(st_addr), .st_data_i(st_data), .st_be_i(st_be), .st_pc_i(st_pc),
      .drain_en_i(drain_en), .dm_we_o(dm_we), .dm_addr_o(dm_addr),
      .dm_wd_o(dm_wd), .dm_be_o(dm_be), .dm_pc_o(dm_pc),
      .ld_addr_i(ld_addr), .ld_hit_be_o(ld_hit_be), .ld_data_o(ld_data),
      .count_o(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        sv;
      logic [31:0] sa, sd;
      logic [3:0]  sb;
      logic [31:0] spc;
      logic        dr;
      logic [31:0] la;
      logic [2:0]  ecnt;
      logic        erdy, ewe;
      logic [31:0] ea, ewd;
      logic [3:0]  ebe;
      logic [31:0] epc;
      logic [3:0]  ehit;
      logic [31:0] eld;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic sv, input logic [31:0] sa, sd, input logic [3:0] sb,
                      input logic [31:0] spc, input logic dr, input logic [31:0] la,
                      input logic [2:0] ecnt, input logic erdy, ewe,
                      input logic [31:0] ea, ewd, input logic [3:0] ebe,
                      input logic [31:0] epc, input logic [3:0] ehit, input logic [31:0] eld);
      vec_t v;
      v.sv = sv; v.sa = sa; v.sd = sd; v.sb = sb; v.spc = spc; v.dr = dr; v.la = la;
      v.ecnt = ecnt; v.erdy = erdy; v.ewe = ewe; v.ea = ea; v.ewd = ewd;
      v.ebe = ebe; v.epc = epc; v.ehit = ehit; v.eld = eld;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act, exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s vec%0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
      end
   endtask

   task automatic idle_inputs();
      st_valid = 0; st_addr = 0; st_data = 0; st_be = 0; st_pc = 0;
      drain_en = 0; ld_addr = 0;
   endtask

   initial begin
      // Fill: each vector holds one cycle's inputs and the pre-edge outputs.
      //   sv sa      sd           sb    spc     dr la      cnt         rdy we ea           ewd                          ebe              epc                ehit           eld
      add(0, 0,     0,           0,    0,      0, 0,      0,          1, 0, 0,           0,                           0,               0,                 0,             0);
      add(1, 'h0,   1,           'hF,  'h100,  0, 0,      0,          1, 0, 0,           0,                           0,               0,                 0,             0);
      add(1, 'h4,   2,           'hF,  'h104,  0, 0,      1,          1, 0, 'h0,         1,                           'hF,             'h100,             'hF,           1);
      add(1, 'h8,   3,           'hF,  'h108,  0, 0,      2,          1, 0, 'h0,         1,                           'hF,             'h100,             'hF,           1);
      add(1, 'hC,   4,           'hF,  'h10C,  0, 0,      3,          1, 0, 'h0,         1,                           'hF,             'h100,             'hF,           1);
      add(1, 'h10,  5,           'hF,  'h110,  0, 0,      4,          0, 0, 'h0,         1,                           'hF,             'h100,             'hF,           1);
      add(1, 'h10,  5,           'hF,  'h110,  0, 'h8,    4,          0, 0, 'h0,         1,                           'hF,             'h100,             'hF,           3);
      add(1, 'h10,  5,           'hF,  'h110,  1, 'h8,    4,          0, 1, 'h0,         1,                           'hF,             'h100,             'hF,           3);
      add(1, 'h10,  5,           'hF,  'h110,  0, 'h8,    3,          1, 0, 'h4,         2,                           'hF,             'h104,             'hF,           3);
      add(0, 0,     0,           0,    0,      1, 'h10,   4,          0, 1, 'h4,         2,                           'hF,             'h104,             'hF,           5);
      add(0, 0,     0,           0,    0,      1, 'h10,   3,          1, 1, 'h8,         3,                           'hF,             'h108,             'hF,           5);
      add(0, 0,     0,           0,    0,      1, 'h10,   2,          1, 1, 'hC,         4,                           'hF,             'h10C,             'hF,           5);
      add(0, 0,     0,           0,    0,      1, 'h10,   1,          1, 1, 'h10,        5,                           'hF,             'h110,             'hF,           5);
      add(0, 0,     0,           0,    0,      0, 'h10,   0,          1, 0, 0,           0,                           0,               0,                 0,             0);
      // Forwarding: newer partial store overrides one lane of an older store.
      add(1, 'h10, 'h11223344,   'hF,  'h200,  0, 'h10,   0,          1, 0, 0,           0,                           0,               0,                 0,             0);
      add(1, 'h10, 'hAA000000,   'h8,  'h204,  0, 'h10,   1,          1, 0, 'h10,        'h11223344,                  'hF,             'h200,             'hF,           'h11223344);
      add(0, 0,     0,           0,    0,      0, 'h10,   C ? 1 : 2,  1, 0, 'h10,        C ? 'hAA223344 : 'h11223344, 'hF,             C ? 'h204 : 'h200, 'hF,           'hAA223344);
      add(0, 0,     0,           0,    0,      0, 'h14,   C ? 1 : 2,  1, 0, 'h10,        C ? 'hAA223344 : 'h11223344, 'hF,             C ? 'h204 : 'h200, 0,             0);
      add(0, 0,     0,           0,    0,      0, 'h11,   C ? 1 : 2,  1, 0, 'h10,        C ? 'hAA223344 : 'h11223344, 'hF,             C ? 'h204 : 'h200, 'hF,           'hAA223344);
      add(0, 0,     0,           0,    0,      1, 'h10,   C ? 1 : 2,  1, 1, 'h10,        C ? 'hAA223344 : 'h11223344, 'hF,             C ? 'h204 : 'h200, 'hF,           'hAA223344);
      add(0, 0,     0,           0,    0,      1, 'h10,   C ? 0 : 1,  1, !C, C ? 0 : 'h10, C ? 0 : 'hAA000000,        C ? 0 : 'h8,     C ? 0 : 'h204,     C ? 0 : 'h8,   C ? 0 : 'hAA000000);
      add(0, 0,     0,           0,    0,      0, 'h10,   0,          1, 0, 0,           0,                           0,               0,                 0,             0);
      // Coalescing candidates: two halves of one word.
      add(1, 'h20, 'h0000BBAA,   'h3,  'h300,  0, 'h20,   0,          1, 0, 0,           0,                           0,               0,                 0,             0);
      add(1, 'h20, 'hCCDD0000,   'hC,  'h304,  0, 'h20,   1,          1, 0, 'h20,        'h0000BBAA,                  'h3,             'h300,             'h3,           'h0000BBAA);
      add(0, 0,     0,           0,    0,      0, 'h20,   C ? 1 : 2,  1, 0, 'h20,        C ? 'hCCDDBBAA : 'h0000BBAA, C ? 'hF : 'h3,   C ? 'h304 : 'h300, 'hF,           'hCCDDBBAA);
      add(0, 0,     0,           0,    0,      1, 'h20,   C ? 1 : 2,  1, 1, 'h20,        C ? 'hCCDDBBAA : 'h0000BBAA, C ? 'hF : 'h3,   C ? 'h304 : 'h300, 'hF,           'hCCDDBBAA);
      add(0, 0,     0,           0,    0,      1, 'h20,   C ? 0 : 1,  1, !C, C ? 0 : 'h20, C ? 0 : 'hCCDD0000,        C ? 0 : 'hC,     C ? 0 : 'h304,     C ? 0 : 'hC,   C ? 0 : 'hCCDD0000);
      add(0, 0,     0,           0,    0,      0, 'h20,   0,          1, 0, 0,           0,                           0,               0,                 0,             0);
      // Zero byte-enable store is accepted and dropped.
      add(1, 'h30, 'hFFFFFFFF,   'h0,  'h308,  0, 'h30,   0,          1, 0, 0,           0,                           0,               0,                 0,             0);
      add(0, 0,     0,           0,    0,      0, 'h30,   0,          1, 0, 0,           0,                           0,               0,                 0,             0);
      // Same word as a head that pops this cycle: must allocate, not merge.
      add(1, 'h40, 'h00000011,   'h1,  'h400,  0, 'h40,   0,          1, 0, 0,           0,                           0,               0,                 0,             0);
      add(1, 'h40, 'h00002200,   'h2,  'h404,  1, 'h40,   1,          1, 1, 'h40,        'h11,                        'h1,             'h400,             'h1,           'h11);
      add(0, 0,     0,           0,    0,      0, 'h40,   1,          1, 0, 'h40,        'h2200,                      'h2,             'h404,             'h2,           'h2200);
      add(0, 0,     0,           0,    0,      1, 'h40,   1,          1, 1, 'h40,        'h2200,                      'h2,             'h404,             'h2,           'h2200);
      add(0, 0,     0,           0,    0,      0, 'h40,   0,          1, 0, 0,           0,                           0,               0,                 0,             0);

      // Power-on reset.
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_count", -1, 32'(count), 0);
      chk("rst_ready", -1, 32'(st_ready), 1);
      chk("rst_dm_we", -1, 32'(dm_we), 0);
      rst_n = 1'b1;

      // Table: drive after the edge, compare at the falling edge.
      foreach (vq[k]) begin
         @(posedge clk); #1;
         st_valid = vq[k].sv; st_addr = vq[k].sa; st_data = vq[k].sd;
         st_be = vq[k].sb; st_pc = vq[k].spc; drain_en = vq[k].dr; ld_addr = vq[k].la;
         @(negedge clk);
         chk("count",     k, 32'(count),     32'(vq[k].ecnt));
         chk("st_ready",  k, 32'(st_ready),  32'(vq[k].erdy));
         chk("dm_we",     k, 32'(dm_we),     32'(vq[k].ewe));
         chk("dm_addr",   k, dm_addr,        vq[k].ea);
         chk("dm_wd",     k, dm_wd,          vq[k].ewd);
         chk("dm_be",     k, 32'(dm_be),     32'(vq[k].ebe));
         chk("dm_pc",     k, dm_pc,          vq[k].epc);
         chk("ld_hit_be", k, 32'(ld_hit_be), 32'(vq[k].ehit));
         chk("ld_data",   k, ld_data,        vq[k].eld);
      end

      // Asynchronous reset with three stores pending, in the middle of a drain.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         st_valid = 1; st_addr = 32'h50 + 32'(4*i); st_data = 32'(i + 7);
         st_be = 4'hF; st_pc = 32'h500 + 32'(4*i); drain_en = 0; ld_addr = 32'h54;
      end
      @(posedge clk); #1;
      st_valid = 0; drain_en = 1;
      @(negedge clk);
      chk("pre_rst_count", 100, 32'(count), 3);
      chk("pre_rst_dm_we", 100, 32'(dm_we), 1);
      chk("pre_rst_hit",   100, 32'(ld_hit_be), 32'hF);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_dm_we", 101, 32'(dm_we), 0);
      chk("async_rst_count", 101, 32'(count), 0);
      chk("async_rst_ready", 101, 32'(st_ready), 1);
      chk("async_rst_hit",   101, 32'(ld_hit_be), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_dm_we", 102 + i, 32'(dm_we), 0);
         chk("post_rst_count", 102 + i, 32'(count), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
